// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier family.
// Provides the controller state encoding, a constant clog2 helper and the
// minimum supported operand width.
package mult_pkg;

  localparam int unsigned MULT_MIN_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mult_state_e;

  // Ceiling log2 for elaboration-time width calculations; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/lsb_find.sv
// Lowest-set-bit locator.
// Ports:
//   vec_i  in  WIDTH   vector to scan
//   idx_o  out IDX_W   index of the lowest set bit (0 when vec_i is zero)
//   any_o  out 1       high when at least one bit of vec_i is set
module lsb_find
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from MSB down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mult_vl_param.sv
// Variable-latency WIDTH x WIDTH -> 2*WIDTH shift/add multiplier.
// One add cycle per set bit of the multiplier magnitude; zero runs cost
// nothing. Signed or unsigned per operation, with abort and zero early exit.
// Ports:
//   clock      in   1        rising-edge clock
//   reset      in   1        asynchronous active-high reset
//   start      in   1        request, accepted only while not busy
//   signed_op  in   1        two's complement operands when high
//   mlier      in   WIDTH    multiplier, sampled on acceptance
//   mcand      in   WIDTH    multiplicand, sampled on acceptance
//   abort      in   1        synchronous cancel, no done pulse
//   busy       out  1        operation in progress
//   done       out  1        one-cycle completion pulse, prodt valid
//   prodt      out  2*WIDTH  product of the last completed operation
//   n_adds     out  CNT_W    add cycles used by the last completed operation
module mult_vl_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prodt,
  output logic [CNT_W-1:0]   n_adds
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned IDX_W = clog2(WIDTH);

  mult_state_e        state_q;
  logic [WIDTH-1:0]   h_q;
  logic [WIDTH-1:0]   q_q;
  logic               neg_q;
  logic [PW-1:0]      acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [PW-1:0]      prodt_q;
  logic [CNT_W-1:0]   n_adds_q;

  logic [IDX_W-1:0]   lsb_idx;
  logic               lsb_any;
  logic [WIDTH-1:0]   mlier_mag_d;
  logic [WIDTH-1:0]   mcand_mag_d;
  logic               neg_d;
  logic [PW-1:0]      acc_d;
  logic [WIDTH-1:0]   q_d;
  logic [PW-1:0]      prodt_d;

  lsb_find #(.WIDTH(WIDTH)) u_lsb_find (
    .vec_i (q_q),
    .idx_o (lsb_idx),
    .any_o (lsb_any)
  );

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
  always_comb begin
    mlier_mag_d = (signed_op && mlier[WIDTH-1]) ? WIDTH'(-mlier) : mlier;
    mcand_mag_d = (signed_op && mcand[WIDTH-1]) ? WIDTH'(-mcand) : mcand;
    neg_d       = signed_op & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
  end

  // One partial product per cycle at the position of the lowest set multiplier bit.
  always_comb begin
    acc_d   = acc_q + (PW'(h_q) << lsb_idx);
    q_d     = q_q & ~(WIDTH'(1) << lsb_idx);
    prodt_d = (neg_q && (acc_q != '0)) ? PW'(-acc_q) : acc_q;
  end

  // Controller and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      h_q      <= '0;
      q_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prodt_q  <= '0;
      n_adds_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Also drops a start presented in IDLE.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              h_q     <= mcand_mag_d;
              q_q     <= mlier_mag_d;
              neg_q   <= neg_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
          CALC: begin
            // A zero multiplicand exits immediately without adds.
            if (!lsb_any || (h_q == '0)) begin
              state_q <= SIGN;
            end else begin
              acc_q <= acc_d;
              q_q   <= q_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          SIGN: begin
            prodt_q  <= prodt_d;
            n_adds_q <= cnt_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign prodt  = prodt_q;
  assign n_adds = n_adds_q;

endmodule

// File: tb/tb_mult_vl_param.sv
// Self-checking bench for mult_vl_param (WIDTH=32) with an expectation queue.
module tb_mult_vl_param;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic          signed_op = 1'b0;
  logic          abort     = 1'b0;
  logic [W-1:0]  mlier     = '0;
  logic [W-1:0]  mcand     = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] prodt;
  logic [CW-1:0] n_adds;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] prod;
    logic [5:0]  nadds;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mult_vl_param #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .mlier     (mlier),
    .mcand     (mcand),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .prodt     (prodt),
    .n_adds    (n_adds)
  );

  always #5 clock = ~clock;

  // Reference: full multiply of extended operands, popcount of |mlier|.
  function automatic exp_t model(input logic s, input logic [31:0] m, input logic [31:0] c);
    exp_t e;
    logic [63:0] xm, xc;
    logic [31:0] am;
    xm = s ? {{32{m[31]}}, m} : {32'd0, m};
    xc = s ? {{32{c[31]}}, c} : {32'd0, c};
    e.prod = xm * xc;
    am = (s && m[31]) ? (~m + 32'd1) : m;
    e.nadds = (m == 32'd0 || c == 32'd0) ? 6'd0 : 6'($countones(am));
    e.lat = int'(e.nadds) + 2;
    return e;
  endfunction

  // Present one request (at posedge+1) and push its expectation.
  task automatic issue(input logic s, input logic [31:0] m, input logic [31:0] c);
    start = 1'b1; signed_op = s; mlier = m; mcand = c;
    sb_q.push_back(model(s, m, c));
    @(posedge clock); #1;
    start = 1'b0;
    mlier = $urandom; mcand = $urandom; signed_op = ~s;
  endtask

  // Wait for done; optionally pulse a bogus start while busy.
  task automatic wait_done(input int max_cyc, input int pulse_at, output int cycles, output bit timeout);
    cycles = 0; timeout = 1'b1;
    while (cycles < max_cyc) begin
      if (cycles == pulse_at) begin start = 1'b1; mlier = 32'd3; mcand = 32'd3; end
      @(posedge clock); #1;
      cycles++;
      start = 1'b0;
      if (done) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (prodt !== 64'd0) begin failures++; $display("FAIL reset_prodt got=%h exp=0", prodt); end
    checks++; if (n_adds !== 6'd0) begin failures++; $display("FAIL reset_nadds got=%0d exp=0", n_adds); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_unsigned_small();
    int cyc; bit to; exp_t e;
    issue(1'b0, 32'd5, 32'd3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL small_busy got=%b exp=1", busy); end
    wait_done(60, -1, cyc, to);
    e = sb_q.pop_front();
    checks++; if (to) begin failures++; $display("FAIL small_timeout got=timeout exp=done"); end
    checks++; if (cyc !== 4) begin failures++; $display("FAIL small_latency got=%0d exp=4", cyc); end
    checks++; if (prodt !== e.prod || prodt !== 64'd15) begin failures++; $display("FAIL small_prodt got=%h exp=%h", prodt, e.prod); end
    checks++; if (n_adds !== 6'd2) begin failures++; $display("FAIL small_nadds got=%0d exp=2", n_adds); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL small_busy_at_done got=%b exp=0", busy); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL small_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_signed();
    int cyc; bit to; exp_t e;
    issue(1'b1, 32'd6, 32'hFFFF_FFF9);
    wait_done(60, -1, cyc, to);
    e = sb_q.pop_front();
    checks++; if (to || cyc !== e.lat) begin failures++; $display("FAIL signed_latency got=%0d exp=%0d", cyc, e.lat); end
    checks++; if (prodt !== 64'hFFFF_FFFF_FFFF_FFD6) begin failures++; $display("FAIL signed_prodt got=%h exp=ffffffffffffffd6", prodt); end
    checks++; if (n_adds !== 6'd2) begin failures++; $display("FAIL signed_nadds got=%0d exp=2", n_adds); end
  endtask

  task automatic test_min_neg();
    int cyc; bit to; exp_t e;
    for (int s = 1; s >= 0; s--) begin
      issue(1'(s), 32'h8000_0000, 32'h8000_0000);
      wait_done(60, -1, cyc, to);
      e = sb_q.pop_front();
      checks++; if (to || cyc !== 3) begin failures++; $display("FAIL minneg_latency mode=%0d got=%0d exp=3", s, cyc); end
      checks++; if (prodt !== 64'h4000_0000_0000_0000 || prodt !== e.prod) begin failures++; $display("FAIL minneg_prodt mode=%0d got=%h exp=4000000000000000", s, prodt); end
      checks++; if (n_adds !== 6'd1) begin failures++; $display("FAIL minneg_nadds mode=%0d got=%0d exp=1", s, n_adds); end
    end
  endtask

  task automatic test_zero();
    int cyc; bit to; exp_t e;
    logic [31:0] ms [3];
    logic [31:0] cs [3];
    ms[0] = 32'd0;        cs[0] = 32'hFFFF_FFFF;
    ms[1] = 32'hFFFF_FFFF; cs[1] = 32'd0;
    ms[2] = 32'd0;        cs[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 2; s++) begin
        issue(1'(s), ms[i], cs[i]);
        wait_done(60, -1, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || cyc !== 2) begin failures++; $display("FAIL zero_latency case=%0d mode=%0d got=%0d exp=2", i, s, cyc); end
        checks++; if (prodt !== 64'd0 || n_adds !== e.nadds) begin failures++; $display("FAIL zero_result case=%0d mode=%0d got=%h/%0d exp=0/0", i, s, prodt, n_adds); end
      end
    end
  endtask

  task automatic test_all_ones();
    int cyc; bit to; exp_t e;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(80, 10, cyc, to);
    e = sb_q.pop_front();
    checks++; if (to || cyc !== 34) begin failures++; $display("FAIL ones_latency got=%0d exp=34", cyc); end
    checks++; if (prodt !== 64'hFFFF_FFFE_0000_0001 || prodt !== e.prod) begin failures++; $display("FAIL ones_prodt got=%h exp=fffffffe00000001", prodt); end
    checks++; if (n_adds !== 6'd32) begin failures++; $display("FAIL ones_nadds got=%0d exp=32", n_adds); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ones_idle_after got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; exp_t e;
    issue(1'b1, 32'h0000_0013, 32'hFFFF_FFFB);
    wait_done(60, -1, cyc, to);
    e = sb_q.pop_front();
    checks++; if (to || prodt !== e.prod) begin failures++; $display("FAIL b2b_first got=%h exp=%h", prodt, e.prod); end
    issue(1'b0, 32'h0000_00F0, 32'h0000_0011);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(60, -1, cyc, to);
    e = sb_q.pop_front();
    checks++; if (to || cyc !== e.lat) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, e.lat); end
    checks++; if (prodt !== e.prod || n_adds !== e.nadds) begin failures++; $display("FAIL b2b_second got=%h/%0d exp=%h/%0d", prodt, n_adds, e.prod, e.nadds); end
  endtask

  task automatic test_abort();
    int cyc; bit to; exp_t e; int dones;
    issue(1'b0, 32'd5, 32'd3);
    wait_done(60, -1, cyc, to);
    e = sb_q.pop_front();
    checks++; if (to || prodt !== e.prod) begin failures++; $display("FAIL abort_prior got=%h exp=%h", prodt, e.prod); end
    start = 1'b1; signed_op = 1'b0; mlier = 32'hFFFF_FFFF; mcand = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b%b exp=00", busy, done); end
    checks++; if (prodt !== 64'd15 || n_adds !== 6'd2) begin failures++; $display("FAIL abort_hold got=%h/%0d exp=f/2", prodt, n_adds); end
    dones = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    // abort together with start in IDLE drops the request
    start = 1'b1; abort = 1'b1; mlier = 32'd7; mcand = 32'd9;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_start_idle got=%b exp=0", busy); end
    dones = 0;
    repeat (6) begin @(posedge clock); #1; if (done) dones++; end
    checks++; if (dones !== 0 || prodt !== 64'd15) begin failures++; $display("FAIL abort_start_drop got=%0d/%h exp=0/f", dones, prodt); end
  endtask

  task automatic test_random();
    int cyc; bit to; exp_t e; logic [31:0] m, c; logic s;
    for (int i = 0; i < 24; i++) begin
      m = $urandom; c = $urandom; s = 1'($urandom_range(0, 1));
      case (i % 4)
        1: m = m & $urandom & $urandom;
        2: begin m = m >> $urandom_range(0, 31); c = c >> $urandom_range(0, 31); end
        3: if (i % 8 == 3) c = 32'd0; else m = 32'h8000_0000;
        default: ;
      endcase
      issue(s, m, c);
      wait_done(60, -1, cyc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || cyc !== e.lat || prodt !== e.prod || n_adds !== e.nadds) begin
        failures++;
        $display("FAIL rand_%0d s=%b m=%h c=%h got=%h/%0d/%0d exp=%h/%0d/%0d", i, s, m, c, prodt, n_adds, cyc, e.prod, e.nadds, e.lat);
      end
    end
  endtask

  task automatic test_async_reset();
    issue(1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL areset_ctrl got=%b%b exp=00", busy, done); end
    checks++; if (prodt !== 64'd0 || n_adds !== 6'd0) begin failures++; $display("FAIL areset_data got=%h/%0d exp=0/0", prodt, n_adds); end
    void'(sb_q.pop_back());
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned_small();
    test_signed();
    test_min_neg();
    test_zero();
    test_all_ones();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset();
    checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_empty got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
